// File: rtl/mips_single_cycle_cpu.sv
// ============================================================================
// Module   : mips_single_cycle_cpu
// Purpose  : Single-cycle 32-bit MIPS subset CPU. Every rising clock edge
//            commits one instruction fetched from an internal ROM that holds
//            a Fibonacci program. It has an internal 32x32 register file and
//            a DMEM_WORDS-deep data RAM.
// Ports    : clk                    - rising-edge clock for all state
//            reset                  - synchronous, active-high
//            RegValue0..RegValue31  - combinational view of registers $0..$31
// Options  : define BNE_EN to decode opcode 000101 (bne) as a branch taken
//            on !Zero. Without it, bne is an unknown opcode and acts as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_single_cycle_cpu #(
   parameter int DMEM_WORDS = 256,
   parameter int IMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] RegValue0,  RegValue1,  RegValue2,  RegValue3,
   output logic [31:0] RegValue4,  RegValue5,  RegValue6,  RegValue7,
   output logic [31:0] RegValue8,  RegValue9,  RegValue10, RegValue11,
   output logic [31:0] RegValue12, RegValue13, RegValue14, RegValue15,
   output logic [31:0] RegValue16, RegValue17, RegValue18, RegValue19,
   output logic [31:0] RegValue20, RegValue21, RegValue22, RegValue23,
   output logic [31:0] RegValue24, RegValue25, RegValue26, RegValue27,
   output logic [31:0] RegValue28, RegValue29, RegValue30, RegValue31
);

   localparam int DADDR_W = $clog2(DMEM_WORDS);
   localparam int IADDR_W = $clog2(IMEM_WORDS);

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef BNE_EN
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif

   localparam logic [3:0] c_ALU_AND = 4'b0000;
   localparam logic [3:0] c_ALU_OR  = 4'b0001;
   localparam logic [3:0] c_ALU_ADD = 4'b0010;
   localparam logic [3:0] c_ALU_SUB = 4'b0110;
   localparam logic [3:0] c_ALU_SLT = 4'b0111;
   localparam logic [3:0] c_ALU_NOR = 4'b1100;

   // Fibonacci program; all other words are NOPs.
   localparam logic [31:0] c_ROM [IMEM_WORDS] = '{
      0:  32'h2001_0001,   // addi $1,$0,1
      1:  32'h2002_000A,   // addi $2,$0,10
      2:  32'h2003_0000,   // addi $3,$0,0
      3:  32'h2004_0001,   // addi $4,$0,1
      4:  32'h2006_0000,   // addi $6,$0,0
      5:  32'hAC04_0190,   // sw   $4,400($0)
      6:  32'h0064_2820,   // add  $5,$3,$4
      7:  32'h0080_1820,   // add  $3,$4,$0
      8:  32'h00A0_2020,   // add  $4,$5,$0
      9:  32'h00C1_3020,   // add  $6,$6,$1
      10: 32'h00C2_382A,   // slt  $7,$6,$2
      11: 32'h10E0_0001,   // beq  $7,$0,+1
      12: 32'h0800_0005,   // j    5
      13: 32'h0800_000D,   // j    13 (halt)
      default: 32'h0000_0000
   };

   logic [31:0] PC, Instruction, pcPlus4, pcNext, branchTarget, jumpTarget;
   logic [31:0] signExtImm, readData1, readData2, aluB;
   logic [31:0] ALUResult, ReadData, WriteData;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, WriteReg;
   logic [1:0]  ALUOp;
   logic [3:0]  ALUControl;
   logic        RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc;
   logic        RegWrite, regWriteMain, branchOnNotEq, functValid, Zero, pcSrc;

   logic [31:0] regFile [32];
   logic [31:0] dataRam [DMEM_WORDS];

   // ---------------- fetch / decode fields ----------------
   assign Instruction = c_ROM[PC[IADDR_W+1:2]];
   assign opcode      = Instruction[31:26];
   assign rs          = Instruction[25:21];
   assign rt          = Instruction[20:16];
   assign rd          = Instruction[15:11];
   assign funct       = Instruction[5:0];
   assign signExtImm  = {{16{Instruction[15]}}, Instruction[15:0]};

   // ---------------- main control ----------------
   always_comb begin
      RegDst        = 1'b0;
      Jump          = 1'b0;
      Branch        = 1'b0;
      branchOnNotEq = 1'b0;
      MemRead       = 1'b0;
      MemtoReg      = 1'b0;
      ALUOp         = 2'b00;
      MemWrite      = 1'b0;
      ALUSrc        = 1'b0;
      regWriteMain  = 1'b0;
      case (opcode)
         c_OP_RTYPE: begin RegDst = 1'b1; ALUOp = 2'b10; regWriteMain = 1'b1; end
         c_OP_ADDI:  begin ALUSrc = 1'b1; regWriteMain = 1'b1; end
         c_OP_LW:    begin ALUSrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; regWriteMain = 1'b1; end
         c_OP_SW:    begin ALUSrc = 1'b1; MemWrite = 1'b1; end
         c_OP_BEQ:   begin Branch = 1'b1; ALUOp = 2'b01; end
`ifdef BNE_EN
         c_OP_BNE:   begin Branch = 1'b1; branchOnNotEq = 1'b1; ALUOp = 2'b01; end
`endif
         c_OP_J:     Jump = 1'b1;
         default:    ;
      endcase
   end

   // ---------------- ALU control ----------------
   // An unrecognised R-type funct must not write the register file.
   always_comb begin
      ALUControl = c_ALU_ADD;
      functValid = 1'b1;
      case (ALUOp)
         2'b01: ALUControl = c_ALU_SUB;
         2'b10: begin
            case (funct)
               6'b100000: ALUControl = c_ALU_ADD;
               6'b100010: ALUControl = c_ALU_SUB;
               6'b100100: ALUControl = c_ALU_AND;
               6'b100101: ALUControl = c_ALU_OR;
               6'b101010: ALUControl = c_ALU_SLT;
               6'b100111: ALUControl = c_ALU_NOR;
               default:   functValid = 1'b0;
            endcase
         end
         default: ALUControl = c_ALU_ADD;
      endcase
   end

   assign RegWrite = regWriteMain & functValid;

   // ---------------- register read / ALU ----------------
   assign readData1 = (rs == 5'd0) ? 32'd0 : regFile[rs];
   assign readData2 = (rt == 5'd0) ? 32'd0 : regFile[rt];
   assign aluB      = ALUSrc ? signExtImm : readData2;

   always_comb begin
      ALUResult = 32'd0;
      case (ALUControl)
         c_ALU_AND: ALUResult = readData1 & aluB;
         c_ALU_OR:  ALUResult = readData1 | aluB;
         c_ALU_ADD: ALUResult = readData1 + aluB;
         c_ALU_SUB: ALUResult = readData1 - aluB;
         c_ALU_SLT: ALUResult = {31'd0, $signed(readData1) < $signed(aluB)};
         c_ALU_NOR: ALUResult = ~(readData1 | aluB);
         default:   ALUResult = 32'd0;
      endcase
   end

   assign Zero = (ALUResult == 32'd0);

   // ---------------- memory / writeback ----------------
   assign ReadData  = dataRam[ALUResult[DADDR_W+1:2]];
   assign WriteReg  = RegDst ? rd : rt;
   assign WriteData = MemtoReg ? ReadData : ALUResult;

   // ---------------- next PC ----------------
   assign pcPlus4      = PC + 32'd4;
   assign branchTarget = pcPlus4 + {signExtImm[29:0], 2'b00};
   assign jumpTarget   = {pcPlus4[31:28], Instruction[25:0], 2'b00};
   assign pcSrc        = Branch & (Zero ^ branchOnNotEq);
   assign pcNext       = Jump ? jumpTarget : (pcSrc ? branchTarget : pcPlus4);

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (reset) PC <= 32'd0;
      else       PC <= pcNext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
      end else if (RegWrite && (WriteReg != 5'd0)) begin
         regFile[WriteReg] <= WriteData;
      end
   end

   // Data RAM keeps its contents across reset; stores are suppressed while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && MemWrite) dataRam[ALUResult[DADDR_W+1:2]] <= readData2;
   end

   // Fields and bits that this subset never consumes.
   logic unusedBits;
   assign unusedBits = ^{MemRead, Instruction[10:6], PC, ALUResult};

   // ---------------- debug register view ----------------
   assign RegValue0  = 32'd0;
   assign RegValue1  = regFile[1];   assign RegValue2  = regFile[2];
   assign RegValue3  = regFile[3];   assign RegValue4  = regFile[4];
   assign RegValue5  = regFile[5];   assign RegValue6  = regFile[6];
   assign RegValue7  = regFile[7];   assign RegValue8  = regFile[8];
   assign RegValue9  = regFile[9];   assign RegValue10 = regFile[10];
   assign RegValue11 = regFile[11];  assign RegValue12 = regFile[12];
   assign RegValue13 = regFile[13];  assign RegValue14 = regFile[14];
   assign RegValue15 = regFile[15];  assign RegValue16 = regFile[16];
   assign RegValue17 = regFile[17];  assign RegValue18 = regFile[18];
   assign RegValue19 = regFile[19];  assign RegValue20 = regFile[20];
   assign RegValue21 = regFile[21];  assign RegValue22 = regFile[22];
   assign RegValue23 = regFile[23];  assign RegValue24 = regFile[24];
   assign RegValue25 = regFile[25];  assign RegValue26 = regFile[26];
   assign RegValue27 = regFile[27];  assign RegValue28 = regFile[28];
   assign RegValue29 = regFile[29];  assign RegValue30 = regFile[30];
   assign RegValue31 = regFile[31];

endmodule

`default_nettype wire

// File: tb/tb_mips_single_cycle_cpu.sv
// ============================================================================
// Module   : tb_mips_single_cycle_cpu
// Purpose  : Self-checking bench for mips_single_cycle_cpu. A program-level
//            reference model tracks PC, registers and the stored RAM word;
//            reset pulses land at random points of the program.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_single_cycle_cpu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   wire  [31:0] rv [32];

   always #5 clk = ~clk;

   mips_single_cycle_cpu dut (
      .clk(clk), .reset(reset),
      .RegValue0(rv[0]),   .RegValue1(rv[1]),   .RegValue2(rv[2]),   .RegValue3(rv[3]),
      .RegValue4(rv[4]),   .RegValue5(rv[5]),   .RegValue6(rv[6]),   .RegValue7(rv[7]),
      .RegValue8(rv[8]),   .RegValue9(rv[9]),   .RegValue10(rv[10]), .RegValue11(rv[11]),
      .RegValue12(rv[12]), .RegValue13(rv[13]), .RegValue14(rv[14]), .RegValue15(rv[15]),
      .RegValue16(rv[16]), .RegValue17(rv[17]), .RegValue18(rv[18]), .RegValue19(rv[19]),
      .RegValue20(rv[20]), .RegValue21(rv[21]), .RegValue22(rv[22]), .RegValue23(rv[23]),
      .RegValue24(rv[24]), .RegValue25(rv[25]), .RegValue26(rv[26]), .RegValue27(rv[27]),
      .RegValue28(rv[28]), .RegValue29(rv[29]), .RegValue30(rv[30]), .RegValue31(rv[31])
   );

   int assertCount = 0;
   int failCount   = 0;

   // Program-level reference model: each PC maps to what that line of the
   // Fibonacci program does to the architectural state.
   logic [31:0] mPC;
   logic [31:0] mr [32];
   logic [31:0] mMem;
   bit          mMemValid = 1'b0;
   bit          storeHappened;
   bit          recordStores = 1'b0;
   logic [31:0] dutStores [$];
   int          cyc;
   int          haltCycle;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPC = 32'd0;
      for (int i = 0; i < 32; i++) mr[i] = 32'd0;
      storeHappened = 1'b0;
   endtask

   task automatic modelStep();
      logic [31:0] nextPc;
      nextPc = mPC + 32'd4;
      storeHappened = 1'b0;
      case (mPC)
         0:  mr[1] = 32'd1;
         4:  mr[2] = 32'd10;
         8:  mr[3] = 32'd0;
         12: mr[4] = 32'd1;
         16: mr[6] = 32'd0;
         20: begin mMem = mr[4]; mMemValid = 1'b1; storeHappened = 1'b1; end
         24: mr[5] = mr[3] + mr[4];
         28: mr[3] = mr[4];
         32: mr[4] = mr[5];
         36: mr[6] = mr[6] + mr[1];
         40: mr[7] = ($signed(mr[6]) < $signed(mr[2])) ? 32'd1 : 32'd0;
         44: if (mr[7] == 32'd0) nextPc = 32'd52;
         48: nextPc = 32'd20;
         52: nextPc = 32'd52;
         default: ;
      endcase
      mPC = nextPc;
   endtask

   task automatic checkState();
      check("PC", dut.PC, mPC);
      for (int i = 0; i < 32; i++) check($sformatf("reg%0d", i), rv[i], mr[i]);
      if (mMemValid) check("ram100", dut.dataRam[100], mMem);
   endtask

   // Decode/datapath expectations for the instruction at the model's PC.
   task automatic checkComb();
      case (mPC)
         0, 4, 8, 12, 16: begin
            check("addi_ctl", {29'd0, dut.RegWrite, dut.ALUSrc, dut.MemWrite}, 32'b110);
            check("addi_alu", dut.ALUResult,
                  (mPC == 32'd4) ? 32'd10 : ((mPC == 32'd0 || mPC == 32'd12) ? 32'd1 : 32'd0));
         end
         20: begin
            check("sw_ctl", {29'd0, dut.RegWrite, dut.ALUSrc, dut.MemWrite}, 32'b011);
            check("sw_addr", dut.ALUResult, 32'd400);
         end
         24, 28, 32, 36: begin
            check("add_ctl", {26'd0, dut.RegDst, dut.RegWrite, dut.ALUControl}, 32'b11_0010);
            check("add_alu", dut.ALUResult,
                  (mPC == 32'd24) ? mr[3] + mr[4] :
                  (mPC == 32'd28) ? mr[4] :
                  (mPC == 32'd32) ? mr[5] : mr[6] + mr[1]);
         end
         40: begin
            check("slt_ctl", {28'd0, dut.ALUControl}, 32'b0111);
            check("slt_alu", dut.ALUResult, ($signed(mr[6]) < $signed(mr[2])) ? 32'd1 : 32'd0);
         end
         44: check("beq_ctl", {30'd0, dut.Branch, dut.Zero}, {30'd0, 1'b1, mr[7] == 32'd0});
         48, 52: check("jump_ctl", {29'd0, dut.Jump, dut.RegWrite, dut.MemWrite}, 32'b100);
         default: ;
      endcase
   endtask

   task automatic doCycle(input logic rst);
      reset = rst;
      @(posedge clk);
      #1;
      if (rst) modelReset();
      else     modelStep();
      checkState();
      checkComb();
      if (recordStores && storeHappened) dutStores.push_back(dut.dataRam[100]);
   endtask

   task automatic checkFinal(input string tag);
      check({tag, "_pc"},   dut.PC,  32'd52);
      check({tag, "_jump"}, {31'd0, dut.Jump}, 32'd1);
      check({tag, "_r0"},   rv[0],   32'd0);
      check({tag, "_r1"},   rv[1],   32'd1);
      check({tag, "_r2"},   rv[2],   32'd10);
      check({tag, "_r3"},   rv[3],   32'd55);
      check({tag, "_r4"},   rv[4],   32'd89);
      check({tag, "_r5"},   rv[5],   32'd89);
      check({tag, "_r6"},   rv[6],   32'd10);
      check({tag, "_r7"},   rv[7],   32'd0);
      check({tag, "_ram"},  dut.dataRam[100], 32'd55);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int fib [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      int n;

      // Reset held for two cycles.
      modelReset();
      doCycle(1'b1);
      doCycle(1'b1);
      check("rst_pc", dut.PC, 32'd0);
      check("rst_instr", dut.Instruction, 32'h2001_0001);
      for (int i = 0; i < 32; i++) check($sformatf("rst_reg%0d", i), rv[i], 32'd0);

      // Initialisation block.
      recordStores = 1'b1;
      haltCycle = -1;
      cyc = 0;
      for (int k = 0; k < 5; k++) begin
         doCycle(1'b0);
         cyc++;
      end
      check("init_pc", dut.PC, 32'd20);
      check("init_r1", rv[1], 32'd1);
      check("init_r2", rv[2], 32'd10);
      check("init_r3", rv[3], 32'd0);
      check("init_r4", rv[4], 32'd1);
      check("init_r6", rv[6], 32'd0);

      // Run to completion; note when the halt PC is first reached.
      for (int k = 5; k < 150; k++) begin
         doCycle(1'b0);
         cyc++;
         if (haltCycle < 0 && dut.PC === 32'd52) haltCycle = cyc;
      end
      recordStores = 1'b0;
      check("halt_cycle", haltCycle, 32'd84);
      check("store_count", dutStores.size(), 32'd10);
      for (int i = 0; i < 10 && i < dutStores.size(); i++)
         check($sformatf("store%0d", i), dutStores[i], fib[i]);
      checkFinal("run1");

      // Reset pulse at cycle 30 of a fresh run.
      doCycle(1'b1);
      for (int k = 0; k < 29; k++) doCycle(1'b0);
      doCycle(1'b1);
      check("mid_rst_pc", dut.PC, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("mid_rst_reg%0d", i), rv[i], 32'd0);
      for (int k = 0; k < 150; k++) doCycle(1'b0);
      checkFinal("run2");

      // Reset pulses of random length at random points in the program.
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 100));
         for (int k = 0; k < n; k++) doCycle(1'b0);
         n = int'($urandom_range(1, 3));
         for (int k = 0; k < n; k++) doCycle(1'b1);
         for (int k = 0; k < 150; k++) doCycle(1'b0);
         checkFinal($sformatf("rand%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mips_single_cycle_cpu.md
Name: mips_single_cycle_cpu

Overview:
Single-cycle 32-bit MIPS subset processor. Each clock edge commits one instruction.
- Internal instruction ROM preloaded with a Fibonacci program.
- Internal 32x32 register file and 256-word data RAM.
- All 32 architectural registers are exported as flat debug outputs for bench observation.
- Top-level block of the CPU design; no external memory bus.

Parameters:
- DMEM_WORDS, 256, data RAM depth in 32-bit words; word index = ALUResult[9:2].
- IMEM_WORDS, 64, instruction ROM depth in words; word index = PC[7:2]; unused words = 0x00000000 (NOP).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high.
- RegValue0 .. RegValue31  output  32 each  combinational view of register file entries $0..$31.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- On reset (sampled at posedge):
  - PC <= 0.
  - All 32 registers <= 0.
  - Data RAM not cleared.
- Every non-reset posedge:
  - Register write (if RegWrite and WriteReg != 0) and data RAM write (if MemWrite) commit.
  - PC <= next PC.
- Combinational datapath:
  - Register reads are asynchronous.
  - $0 always reads 0; writes to $0 are ignored.
- Supported instructions:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111.
  - addi 001000 (sign-extended immediate).
  - lw 100011, sw 101011 (address = rs + sext(imm)).
  - beq 000100: target = PC+4 + (sext(imm)<<2) when Zero.
  - j 000010: target = {PC+4[31:28], addr26, 00}.
- Control outputs per opcode: RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite.
  - ALUOp 00 = add (lw/sw/addi), 01 = sub (beq), 10 = R-type funct decode.
  - Unknown opcode or funct: all write enables 0, PC+4.
- ALUControl[3:0] codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (signed), NOR 1100.
  - Zero = (ALUResult == 0).
  - Arithmetic wraps modulo 2^32; no overflow traps.
- WriteReg = rd if RegDst else rt. WriteData = RAM ReadData if MemtoReg else ALUResult.
- Internal signal names the verifier probes hierarchically: PC, Instruction, ALUControl, Zero, ALUResult, ReadData, RegWrite, WriteReg, WriteData, plus the control signals listed above.
- ROM program (word index: instruction):
  - 0 addi $1,$0,1
  - 1 addi $2,$0,10
  - 2 addi $3,$0,0
  - 3 addi $4,$0,1
  - 4 addi $6,$0,0
  - 5 sw $4,400($0)
  - 6 add $5,$3,$4
  - 7 add $3,$4,$0
  - 8 add $4,$5,$0
  - 9 add $6,$6,$1
  - 10 slt $7,$6,$2
  - 11 beq $7,$0,+1
  - 12 j 5
  - 13 j 13 (halt loop)
- Program result:
  - 84 instructions execute before reaching the halt PC 52.
  - Final registers: $1=1, $2=10, $3=55, $4=89, $5=89, $6=10, $7=0.
  - RAM word 100 = 55.
- Reset asserted mid-program restarts from PC 0 with cleared registers on the next edge.

Optional Feature:
BNE_EN:
- Defined: opcode 000101 (bne) decodes as a branch taken when !Zero, using ALUOp 01.
- Undefined: opcode 000101 is treated as an unknown-opcode NOP.
- The ROM program does not use bne in either build.

Test Plan:
- Hold reset 2 cycles -> PC=0, RegValue0..31 all 0, Instruction=0x20010001.
- Release reset, run 5 cycles -> $1=1, $2=10, $3=0, $4=1, $6=0, PC=20; RegWrite=1, ALUSrc=1 on each addi.
- At PC=20 -> MemWrite=1, ALUResult=400, RAM word 100 <= $4. Stored values over iterations: 1,1,2,3,5,8,13,21,34,55.
- At PC=40 (slt) with $6=3 -> ALUControl=0111, ALUResult=1, $7=1. Following beq: Branch=1, Zero=0, not taken, PC=48.
- Run 150 cycles -> PC stuck at 52 with Jump=1. Final $3=55, $4=89, $5=89, $6=10, $7=0; RegValue0=0 throughout.
- Assert reset at cycle 30 for 1 cycle -> next PC=0, all registers 0, program re-executes to the same final state.
